de1_blinker_sysid_checker: RTL and testbench
============================================

# de1_blinker_sysid_checker

Boot-time consumer of the system-ID slave. The block is a small Avalon-MM read master that fetches the ID word (address 0) and the timestamp word (address 1) from the sysid control slave. It compares both against build-time constants, latches pass/fail flags and drives a status LED: blinking on pass, solid on fail. It sits directly downstream of the sysid slave in the de1_blinker system, either on the same interconnect or wired point-to-point.

## Interface
Parameters:
- EXPECTED_ID, 32'h0000_1337: required value of word 0 (4919).
- EXPECTED_TS, 32'h6796_9545: required value of word 1 (1737921861).
- CHECK_TIMESTAMP, 1: 1 means a timestamp mismatch fails the check; 0 means the timestamp is captured but ignored for `pass`.
- READ_LATENCY, 0: clocks from the edge that samples `avm_read` to the edge that captures `avm_readdata`; legal range 0..7.
- BLINK_DIV, 25_000_000: LED half-period in clocks on pass; minimum 1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to re-run the check; honoured only in DONE.
- avm_address  out  1  word select to the sysid slave.
- avm_read  out  1  read strobe, one cycle per access.
- avm_readdata  in  32  data from the sysid slave.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.
- id_ok  out  1  id_value == EXPECTED_ID.
- ts_ok  out  1  ts_value == EXPECTED_TS.
- pass  out  1  id_ok & (ts_ok | ~CHECK_TIMESTAMP).
- done  out  1  check finished; results valid.
- busy  out  1  a check is in progress.
- led  out  1  status LED.

## Operation
- States:
  - IDLE → RD_ID → [WAIT_ID] → RD_TS → [WAIT_TS] → CMP → DONE.
  - The WAIT states are entered only when READ_LATENCY > 0 and last READ_LATENCY cycles, timed by a 3-bit down-counter.
- Reset values:
  - State is IDLE.
  - All outputs are 0, including id_value, ts_value and led.
  - An auto-start flag is set, so IDLE always advances to RD_ID on the first edge after reset.
- RD_ID:
  - avm_read=1 and avm_address=0 for exactly one cycle.
  - avm_address holds its value through the following WAIT state.
- Capture:
  - avm_readdata is captured into id_value (or ts_value) at the edge that leaves RD_x when READ_LATENCY=0, otherwise at the edge that leaves WAIT_x.
  - avm_readdata is ignored at every other edge.
- RD_TS: same as RD_ID, with avm_address=1.
- CMP: registers id_ok and ts_ok from the captured words.
- DONE:
  - Asserts done and pass.
  - busy=1 in every state except DONE and the reset state.
- LED:
  - led=0 while busy.
  - In DONE with pass=1, led starts at 0 and toggles every BLINK_DIV clocks.
  - In DONE with pass=0, led is steady 1.
- start:
  - Ignored outside DONE.
  - In DONE, start clears done, pass, id_ok, ts_ok, led and the blink counter, then enters RD_ID on the next edge.
  - id_value and ts_value are overwritten only when the new captures occur.
- Reset mid-operation: all state returns to reset values at that edge; avm_read is low the following cycle; the check re-runs automatically once reset deasserts.

## Timing
- Edge 0 is the first rising edge with reset=0. For READ_LATENCY=L:
  - avm_read is high in the cycle after edge 0 (address 0) and in the cycle after edge 1+L (address 1).
  - id captured at edge 1+L.
  - ts captured at edge 2+2L.
  - id_ok/ts_ok valid after edge 3+2L.
  - done=1 and busy=0 after edge 4+2L.
- Exactly two read strobes per check; never two consecutive avm_read cycles when L>0.
- Blink counter: width $clog2(BLINK_DIV+1); wraps to 0 on the toggle.

## Structure
- Package de1_blinker_sysid_pkg holds:
  - the state enum;
  - ADDR_ID=1'b0 and ADDR_TS=1'b1;
  - default EXPECTED_ID and EXPECTED_TS constants.
- Sub-module de1_blinker_blink_divider holds the BLINK_DIV counter and toggle flop, with enable and synchronous clear inputs.
- The FSM, capture registers and comparators stay in the top module.

## Test plan
- Pass case, L=0: bench slave returns 0x00001337 / 0x67969545 → exactly 2 read pulses at addresses 0 then 1; done=1 after edge 4; id_value=0x00001337, ts_value=0x67969545, pass=1.
- ID mismatch: slave returns 0x00001338 → id_ok=0, pass=0, led steady 1 in DONE.
- Timestamp mismatch (0x67969546):
  - CHECK_TIMESTAMP=1 → pass=0.
  - CHECK_TIMESTAMP=0 → ts_ok=0 and pass=1.
- L=2, with slave driving 0xDEADBEEF except at the capture edges → correct values captured; done after edge 8; one-cycle read strobes.
- BLINK_DIV=4, pass → led=0 on entry to DONE, then toggles every 4 clocks (period 8).
- start during busy is ignored. start in DONE → done drops next edge and the check repeats. Reset asserted in WAIT_ID → all outputs 0 at next edge, then the full sequence re-runs.

Source files
------------

// File: rtl/de1_blinker_sysid_pkg.sv
// -----------------------------------------------------------------------------
// de1_blinker_sysid_pkg
// Shared definitions for the boot-time sysid checker:
//   - state_t          : checker FSM states
//   - ADDR_ID/ADDR_TS  : word selects on the sysid control slave
//   - DEFAULT_EXPECTED_ID/TS : build-time reference values
//   - is_read_state()  : true for states that issue a read strobe
// -----------------------------------------------------------------------------
package de1_blinker_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_WAIT_ID = 3'd2,
        ST_RD_TS   = 3'd3,
        ST_WAIT_TS = 3'd4,
        ST_CMP     = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_1337;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h6796_9545;

    function automatic logic is_read_state(input state_t s);
        return (s == ST_RD_ID) || (s == ST_RD_TS);
    endfunction

endpackage

// File: rtl/de1_blinker_blink_divider.sv
// -----------------------------------------------------------------------------
// de1_blinker_blink_divider
// Divides the clock down to an LED toggle with half-period BLINK_DIV clocks.
// Ports:
//   i_clock  in  system clock
//   i_reset  in  synchronous active-high reset
//   i_clr    in  synchronous clear of counter and LED (highest priority)
//   i_solid  in  force LED steady on, counter held at zero
//   i_en     in  count enable; LED toggles after BLINK_DIV enabled clocks
//   o_led    out registered LED
// -----------------------------------------------------------------------------
module de1_blinker_blink_divider #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_solid,
    input  logic i_en,
    output logic o_led
);

    localparam int CNT_W = $clog2(BLINK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_led;

    // Half-period counter and LED toggle flop; counter wraps to zero on toggle.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else if (i_solid) begin
            r_cnt <= '0;
            r_led <= 1'b1;
        end else if (i_en) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_led <= ~r_led;
            end else begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/de1_blinker_sysid_checker.sv
// -----------------------------------------------------------------------------
// de1_blinker_sysid_checker
// Avalon-MM read master that fetches the sysid ID word (address 0) and
// timestamp word (address 1), compares them with build-time constants and
// reports the result on flags and a status LED (blinking = pass, solid = fail).
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   start                 re-run request, honoured only in DONE
//   avm_address/avm_read  read master command (one-cycle strobes)
//   avm_readdata          read data from the sysid slave
//   id_value/ts_value     captured words
//   id_ok/ts_ok/pass      comparison results
//   done/busy             progress flags
//   led                   status LED
// -----------------------------------------------------------------------------
module de1_blinker_sysid_checker
    import de1_blinker_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID     = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS     = DEFAULT_EXPECTED_TS,
    parameter int          CHECK_TIMESTAMP = 1,
    parameter int          READ_LATENCY    = 0,
    parameter int          BLINK_DIV       = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        done,
    output logic        busy,
    output logic        led
);

    localparam logic       LAT_ZERO  = (READ_LATENCY == 0);
    localparam logic [2:0] WAIT_LOAD = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;
    localparam logic       CHECK_TS  = (CHECK_TIMESTAMP != 0);

    state_t      r_state;
    state_t      w_next;
    logic        r_auto_start;
    logic [2:0]  r_wait_cnt;
    logic        r_avm_read;
    logic        r_avm_address;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_pass;
    logic        r_done;
    logic        r_busy;
    logic        w_capture_id;
    logic        w_capture_ts;
    logic        w_load_wait;
    logic        w_restart;
    logic        w_done_hold;
    logic        w_pass_calc;
    logic        w_led;

    // Next-state decode and capture strobes.
    always_comb begin
        w_next       = r_state;
        w_capture_id = 1'b0;
        w_capture_ts = 1'b0;
        w_load_wait  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_auto_start) begin
                    w_next = ST_RD_ID;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RD_ID: begin
                if (LAT_ZERO) begin
                    w_next       = ST_RD_TS;
                    w_capture_id = 1'b1;
                end else begin
                    w_next      = ST_WAIT_ID;
                    w_load_wait = 1'b1;
                end
            end
            ST_WAIT_ID: begin
                if (r_wait_cnt == 3'd0) begin
                    w_next       = ST_RD_TS;
                    w_capture_id = 1'b1;
                end else begin
                    w_next = ST_WAIT_ID;
                end
            end
            ST_RD_TS: begin
                if (LAT_ZERO) begin
                    w_next       = ST_CMP;
                    w_capture_ts = 1'b1;
                end else begin
                    w_next      = ST_WAIT_TS;
                    w_load_wait = 1'b1;
                end
            end
            ST_WAIT_TS: begin
                if (r_wait_cnt == 3'd0) begin
                    w_next       = ST_CMP;
                    w_capture_ts = 1'b1;
                end else begin
                    w_next = ST_WAIT_TS;
                end
            end
            ST_CMP: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    w_next = ST_RD_ID;
                end else begin
                    w_next = ST_DONE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // done/pass/busy settle one clock after DONE is entered; a start pulse
    // in DONE drops them again on the edge that leaves DONE.
    assign w_restart   = (r_state == ST_DONE) && start;
    assign w_done_hold = (r_state == ST_DONE) && (w_next == ST_DONE);
    assign w_pass_calc = r_id_ok & (r_ts_ok | ~CHECK_TS);

    // FSM state, bus command, capture and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_auto_start  <= 1'b1;
            r_wait_cnt    <= 3'd0;
            r_avm_read    <= 1'b0;
            r_avm_address <= ADDR_ID;
            r_id_value    <= 32'h0000_0000;
            r_ts_value    <= 32'h0000_0000;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_pass        <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != ST_IDLE) begin
                r_auto_start <= 1'b0;
            end

            if (w_load_wait) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if (r_wait_cnt != 3'd0) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end

            // Strobe and address come from the next state so they are
            // registered yet aligned with RD_ID/RD_TS; the address holds
            // through the following wait.
            r_avm_read <= is_read_state(w_next);
            if (w_next == ST_RD_ID) begin
                r_avm_address <= ADDR_ID;
            end else if (w_next == ST_RD_TS) begin
                r_avm_address <= ADDR_TS;
            end

            if (w_capture_id) begin
                r_id_value <= avm_readdata;
            end
            if (w_capture_ts) begin
                r_ts_value <= avm_readdata;
            end

            if (r_state == ST_CMP) begin
                r_id_ok <= (r_id_value == EXPECTED_ID);
                r_ts_ok <= (r_ts_value == EXPECTED_TS);
            end else if (w_restart) begin
                r_id_ok <= 1'b0;
                r_ts_ok <= 1'b0;
            end

            r_done <= w_done_hold;
            r_pass <= w_done_hold & w_pass_calc;
            r_busy <= ~w_done_hold && (w_next != ST_IDLE);
        end
    end

    de1_blinker_blink_divider #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .i_clock (clock),
        .i_reset (reset),
        .i_clr   (w_restart),
        .i_solid (w_done_hold & ~w_pass_calc),
        .i_en    (r_done & r_pass),
        .o_led   (w_led)
    );

    assign avm_address = r_avm_address;
    assign avm_read    = r_avm_read;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign pass        = r_pass;
    assign done        = r_done;
    assign busy        = r_busy;
    assign led         = w_led;

endmodule

// File: tb/tb_de1_blinker_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_de1_blinker_sysid_checker
// Directed bench with three checker instances sharing clock, reset and slave
// word values:
//   u0 : READ_LATENCY=0, CHECK_TIMESTAMP=1, BLINK_DIV=4
//   u2 : READ_LATENCY=2, CHECK_TIMESTAMP=1, BLINK_DIV=4
//   un : READ_LATENCY=0, CHECK_TIMESTAMP=0, BLINK_DIV=4
// Each instance has its own start and its own slave model.
// -----------------------------------------------------------------------------
module tb_de1_blinker_sysid_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        st0, st2, stn;
    logic [31:0] id_word, ts_word;

    logic        rd0, ad0, iok0, tok0, ps0, dn0, by0, ld0;
    logic [31:0] id0, ts0, rdata0;
    logic        rd2, ad2, iok2, tok2, ps2, dn2, by2, ld2;
    logic [31:0] id2, ts2, rdata2;
    logic        rdn, adn, iokn, tokn, psn, dnn, byn, ldn;
    logic [31:0] idn, tsn, rdatan;

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;
    int cnt0 = 0, cnt2 = 0, cntn = 0;
    logic prev2 = 1'b0, consec2 = 1'b0;
    logic d1v = 1'b0, d1a = 1'b0, d2v = 1'b0, d2a = 1'b0;

    always #5 clk = ~clk;

    de1_blinker_sysid_checker #(.CHECK_TIMESTAMP(1), .READ_LATENCY(0), .BLINK_DIV(4)) u0 (
        .clock(clk), .reset(reset), .start(st0), .avm_address(ad0), .avm_read(rd0),
        .avm_readdata(rdata0), .id_value(id0), .ts_value(ts0), .id_ok(iok0), .ts_ok(tok0),
        .pass(ps0), .done(dn0), .busy(by0), .led(ld0));

    de1_blinker_sysid_checker #(.CHECK_TIMESTAMP(1), .READ_LATENCY(2), .BLINK_DIV(4)) u2 (
        .clock(clk), .reset(reset), .start(st2), .avm_address(ad2), .avm_read(rd2),
        .avm_readdata(rdata2), .id_value(id2), .ts_value(ts2), .id_ok(iok2), .ts_ok(tok2),
        .pass(ps2), .done(dn2), .busy(by2), .led(ld2));

    de1_blinker_sysid_checker #(.CHECK_TIMESTAMP(0), .READ_LATENCY(0), .BLINK_DIV(4)) un (
        .clock(clk), .reset(reset), .start(stn), .avm_address(adn), .avm_read(rdn),
        .avm_readdata(rdatan), .id_value(idn), .ts_value(tsn), .id_ok(iokn), .ts_ok(tokn),
        .pass(psn), .done(dnn), .busy(byn), .led(ldn));

    // Zero-latency slaves: data valid only while the strobe is high.
    assign rdata0 = (rd0 === 1'b1) ? (ad0 ? ts_word : id_word) : 32'hDEAD_BEEF;
    assign rdatan = (rdn === 1'b1) ? (adn ? ts_word : id_word) : 32'hDEAD_BEEF;
    // Two-cycle slave: data valid only in the cycle ending at the capture edge.
    assign rdata2 = d2v ? (d2a ? ts_word : id_word) : 32'hDEAD_BEEF;

    // Slave pipeline, strobe counters and back-to-back strobe detector.
    always @(posedge clk) begin
        d1v <= (rd2 === 1'b1);
        d1a <= ad2;
        d2v <= d1v;
        d2a <= d1a;
        if (rd0 === 1'b1) cnt0 <= cnt0 + 1;
        if (rd2 === 1'b1) cnt2 <= cnt2 + 1;
        if (rdn === 1'b1) cntn <= cntn + 1;
        prev2 <= (rd2 === 1'b1);
        if ((rd2 === 1'b1) && prev2) consec2 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, ecnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic tick_to(input int n);
        while (ecnt < n) tick();
    endtask

    initial begin
        reset = 1'b1; st0 = 1'b0; st2 = 1'b0; stn = 1'b0;
        id_word = 32'h0000_1337; ts_word = 32'h6796_9545;
        tick(); tick(); tick();
        // Reset state
        chk("rst_read0", {31'd0, rd0}, 32'd0);
        chk("rst_busy0", {31'd0, by0}, 32'd0);
        chk("rst_done0", {31'd0, dn0}, 32'd0);
        chk("rst_led0",  {31'd0, ld0}, 32'd0);
        chk("rst_id0",   id0, 32'd0);
        chk("rst_ts2",   ts2, 32'd0);

        // Pass case: first edge with reset low is edge 0
        reset = 1'b0;
        ecnt = -1;
        tick_to(0);
        chk("e0_read0", {31'd0, rd0}, 32'd1);
        chk("e0_addr0", {31'd0, ad0}, 32'd0);
        chk("e0_busy0", {31'd0, by0}, 32'd1);
        tick_to(1);
        chk("e1_read0", {31'd0, rd0}, 32'd1);
        chk("e1_addr0", {31'd0, ad0}, 32'd1);
        chk("e1_id0",   id0, 32'h0000_1337);
        chk("e1_read2", {31'd0, rd2}, 32'd0);
        tick_to(2);
        chk("e2_ts0",   ts0, 32'h6796_9545);
        chk("e2_read0", {31'd0, rd0}, 32'd0);
        tick_to(3);
        chk("e3_idok0", {31'd0, iok0}, 32'd1);
        chk("e3_tsok0", {31'd0, tok0}, 32'd1);
        chk("e3_done0", {31'd0, dn0}, 32'd0);
        chk("e3_read2", {31'd0, rd2}, 32'd1);
        chk("e3_addr2", {31'd0, ad2}, 32'd1);
        chk("e3_id2",   id2, 32'h0000_1337);
        tick_to(4);
        chk("e4_done0", {31'd0, dn0}, 32'd1);
        chk("e4_busy0", {31'd0, by0}, 32'd0);
        chk("e4_pass0", {31'd0, ps0}, 32'd1);
        chk("e4_led0",  {31'd0, ld0}, 32'd0);
        chk("e4_passn", {31'd0, psn}, 32'd1);
        chk("e4_busy2", {31'd0, by2}, 32'd1);
        // start while u2 is busy must be ignored
        st2 = 1'b1;
        tick_to(5);
        st2 = 1'b0;
        tick_to(7);
        chk("e7_led0",  {31'd0, ld0}, 32'd0);
        chk("e7_done2", {31'd0, dn2}, 32'd0);
        chk("e7_idok2", {31'd0, iok2}, 32'd1);
        tick_to(8);
        chk("e8_led0",  {31'd0, ld0}, 32'd1);
        chk("e8_done2", {31'd0, dn2}, 32'd1);
        chk("e8_busy2", {31'd0, by2}, 32'd0);
        chk("e8_pass2", {31'd0, ps2}, 32'd1);
        chk("e8_ts2",   ts2, 32'h6796_9545);
        chk("e8_led2",  {31'd0, ld2}, 32'd0);
        chk("e8_cnt0",  cnt0, 32'd2);
        chk("e8_cnt2",  cnt2, 32'd2);
        chk("e8_cntn",  cntn, 32'd2);

        // ID mismatch via restart of u0
        id_word = 32'h0000_1338;
        st0 = 1'b1;
        tick_to(9);
        st0 = 1'b0;
        chk("rs_done0", {31'd0, dn0}, 32'd0);
        chk("rs_led0",  {31'd0, ld0}, 32'd0);
        chk("rs_pass0", {31'd0, ps0}, 32'd0);
        chk("rs_idok0", {31'd0, iok0}, 32'd0);
        chk("rs_busy0", {31'd0, by0}, 32'd1);
        chk("rs_id0",   id0, 32'h0000_1337);
        chk("rs_read0", {31'd0, rd0}, 32'd1);
        tick_to(13);
        chk("idm_done0", {31'd0, dn0}, 32'd1);
        chk("idm_pass0", {31'd0, ps0}, 32'd0);
        chk("idm_idok0", {31'd0, iok0}, 32'd0);
        chk("idm_tsok0", {31'd0, tok0}, 32'd1);
        chk("idm_led0",  {31'd0, ld0}, 32'd1);
        chk("idm_id0",   id0, 32'h0000_1338);
        tick_to(14);
        chk("idm_led0b", {31'd0, ld0}, 32'd1);
        chk("idm_cnt0",  cnt0, 32'd4);

        // Timestamp mismatch, checked (u0) and ignored (un)
        id_word = 32'h0000_1337;
        ts_word = 32'h6796_9546;
        st0 = 1'b1; stn = 1'b1;
        tick_to(15);
        st0 = 1'b0; stn = 1'b0;
        tick_to(19);
        chk("tsm_pass0", {31'd0, ps0}, 32'd0);
        chk("tsm_idok0", {31'd0, iok0}, 32'd1);
        chk("tsm_tsok0", {31'd0, tok0}, 32'd0);
        chk("tsm_led0",  {31'd0, ld0}, 32'd1);
        chk("tsm_donen", {31'd0, dnn}, 32'd1);
        chk("tsm_passn", {31'd0, psn}, 32'd1);
        chk("tsm_tsokn", {31'd0, tokn}, 32'd0);
        chk("tsm_tsn",   tsn, 32'h6796_9546);
        tick_to(22);
        chk("tsm_ledn",  {31'd0, ldn}, 32'd0);
        tick_to(23);
        chk("tsm_ledn1", {31'd0, ldn}, 32'd1);

        // Reset while u2 sits in WAIT_ID
        ts_word = 32'h6796_9545;
        st2 = 1'b1;
        tick_to(24);
        st2 = 1'b0;
        chk("w_read2", {31'd0, rd2}, 32'd1);
        chk("w_addr2", {31'd0, ad2}, 32'd0);
        chk("w_done2", {31'd0, dn2}, 32'd0);
        tick_to(25);
        chk("w_busy2",  {31'd0, by2}, 32'd1);
        chk("w_read2b", {31'd0, rd2}, 32'd0);
        reset = 1'b1;
        tick_to(26);
        chk("mr_id2",   id2, 32'd0);
        chk("mr_ts2",   ts2, 32'd0);
        chk("mr_busy2", {31'd0, by2}, 32'd0);
        chk("mr_read2", {31'd0, rd2}, 32'd0);
        chk("mr_led0",  {31'd0, ld0}, 32'd0);
        chk("mr_idok0", {31'd0, iok0}, 32'd0);
        reset = 1'b0;
        ecnt = -1;
        tick_to(0);
        chk("rr_read2", {31'd0, rd2}, 32'd1);
        tick_to(4);
        chk("rr_done0", {31'd0, dn0}, 32'd1);
        chk("rr_pass0", {31'd0, ps0}, 32'd1);
        chk("rr_done2", {31'd0, dn2}, 32'd0);
        tick_to(8);
        chk("rr_done2b", {31'd0, dn2}, 32'd1);
        chk("rr_pass2",  {31'd0, ps2}, 32'd1);
        chk("rr_id2",    id2, 32'h0000_1337);
        chk("rr_ts2",    ts2, 32'h6796_9545);
        chk("rr_cnt0",   cnt0, 32'd8);
        chk("rr_cnt2",   cnt2, 32'd5);
        chk("rr_cntn",   cntn, 32'd6);
        chk("rr_consec2", {31'd0, consec2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
